// File: rtl/membus_arbiter_if.sv
// Bundle of requester, main-memory and debug signals around membus_arbiter.
// The arbiter uses the slave modport; the requesters/memory model use master.
interface membus_arbiter_if;
  logic        swc;
  logic        wbreq;
  logic [26:0] wbadr;
  logic [31:0] wbwdata;
  logic [3:0]  wbbyteen;
  logic        dreq;
  logic        drwb;
  logic [26:0] dadr;
  logic [31:0] dwdata;
  logic [3:0]  dbyteen;
  logic        ireq;
  logic        irwb;
  logic [26:0] iadr;
  logic [31:0] iwdata;
  logic [3:0]  ibyteen;
  logic        wbdone;
  logic        ddone;
  logic        idone;
  logic [31:0] rdata;
  logic        err;
  logic [26:0] memadr;
  logic [31:0] memwdata;
  logic [3:0]  membyteen;
  logic        memrwb;
  logic        memen;
  logic [31:0] memrdata;
  logic        memdone;
  logic [1:0]  dbg_state;
  logic [1:0]  dbg_owner;
  logic [7:0]  dbg_wbcnt;

  modport slave (
    input  swc,
    input  wbreq, wbadr, wbwdata, wbbyteen,
    input  dreq, drwb, dadr, dwdata, dbyteen,
    input  ireq, irwb, iadr, iwdata, ibyteen,
    input  memrdata, memdone,
    output wbdone, ddone, idone, rdata, err,
    output memadr, memwdata, membyteen, memrwb, memen,
    output dbg_state, dbg_owner, dbg_wbcnt
  );

  modport master (
    output swc,
    output wbreq, wbadr, wbwdata, wbbyteen,
    output dreq, drwb, dadr, dwdata, dbyteen,
    output ireq, irwb, iadr, iwdata, ibyteen,
    output memrdata, memdone,
    input  wbdone, ddone, idone, rdata, err,
    input  memadr, memwdata, membyteen, memrwb, memen,
    input  dbg_state, dbg_owner, dbg_wbcnt
  );
endinterface

// File: rtl/membus_arbiter.sv
// Three-way main-memory arbiter (write buffer, dcache, icache) with WB
// starvation limit and a BUSY-phase timeout that aborts with err.
module membus_arbiter #(
  parameter int MAXWB   = 4,
  parameter int TIMEOUT = 255
) (
  input logic             ph1,
  input logic             resetb,
  membus_arbiter_if.slave bus
);
  // Handshake: a requester raises req with a stable payload and holds both
  // until its done pulse; done is a single cycle and err/rdata ride with it.
  // memdone is only looked at in BUSY; memen marks the transaction window.

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_WB   = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;
  localparam logic [1:0] OWN_I    = 2'd3;

  localparam int             WBW    = (MAXWB < 1) ? 1 : $clog2(MAXWB + 1);
  localparam logic [WBW-1:0] WB_MAX = WBW'(MAXWB);
  localparam logic [7:0]     TO_LIM = 8'(TIMEOUT);

  logic [1:0]     r_state;
  logic [1:0]     r_owner;
  logic [WBW-1:0] r_wbcnt;
  logic [7:0]     r_tcnt;
  logic [26:0]    r_adr;
  logic [31:0]    r_wdata;
  logic [3:0]     r_byteen;
  logic           r_rwb;
  logic [31:0]    r_rdata;
  logic           r_err;

  logic       w_cache_req;
  logic       w_cache_first;
  logic [1:0] w_grant;
  logic [7:0] w_tcnt_nxt;
  logic       w_busy;
  logic       w_done;

  assign w_cache_req   = bus.dreq | bus.ireq;
  // Once the WB has won MAXWB times in a row over a waiting cache, it yields.
  assign w_cache_first = w_cache_req && (r_wbcnt == WB_MAX);
  assign w_tcnt_nxt    = r_tcnt + 8'd1;

  always_comb begin
    w_grant = OWN_NONE;
    if (bus.wbreq && !w_cache_first) begin
      w_grant = OWN_WB;
    end else if (w_cache_req) begin
      if (!bus.swc) w_grant = bus.dreq ? OWN_D : OWN_I;
      else          w_grant = bus.ireq ? OWN_I : OWN_D;
    end
  end

  always_ff @(posedge ph1 or negedge resetb) begin
    if (!resetb) begin
      r_state  <= S_IDLE;
      r_owner  <= OWN_NONE;
      r_wbcnt  <= '0;
      r_tcnt   <= 8'd0;
      r_adr    <= 27'd0;
      r_wdata  <= 32'd0;
      r_byteen <= 4'd0;
      r_rwb    <= 1'b1;
      r_rdata  <= 32'd0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_err <= 1'b0;
          if (w_grant != OWN_NONE) begin
            r_state <= S_BUSY;
            r_owner <= w_grant;
            r_tcnt  <= 8'd0;
            case (w_grant)
              OWN_WB: begin
                r_adr    <= bus.wbadr;
                r_wdata  <= bus.wbwdata;
                r_byteen <= bus.wbbyteen;
                r_rwb    <= 1'b0;
              end
              OWN_D: begin
                r_adr    <= bus.dadr;
                r_wdata  <= bus.dwdata;
                r_byteen <= bus.dbyteen;
                r_rwb    <= bus.drwb;
              end
              default: begin
                r_adr    <= bus.iadr;
                r_wdata  <= bus.iwdata;
                r_byteen <= bus.ibyteen;
                r_rwb    <= bus.irwb;
              end
            endcase
            if (w_grant == OWN_WB) begin
              if (!w_cache_req)           r_wbcnt <= '0;
              else if (r_wbcnt != WB_MAX) r_wbcnt <= r_wbcnt + WBW'(1);
            end else begin
              r_wbcnt <= '0;
            end
          end
        end
        S_BUSY: begin
          if (bus.memdone) begin
            if (r_rwb) r_rdata <= bus.memrdata;
            r_state <= S_DONE;
          end else if (w_tcnt_nxt == TO_LIM) begin
            r_tcnt  <= w_tcnt_nxt;
            r_err   <= 1'b1;
            r_rdata <= 32'hDEADBEEF;
            r_state <= S_DONE;
          end else begin
            r_tcnt <= w_tcnt_nxt;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_owner <= OWN_NONE;
          r_err   <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_owner <= OWN_NONE;
        end
      endcase
    end
  end

  assign w_busy = (r_state == S_BUSY);
  assign w_done = (r_state == S_DONE);

  // Bus is parked at zero with read polarity whenever no transaction is live.
  assign bus.memen     = w_busy;
  assign bus.memadr    = w_busy ? r_adr    : 27'd0;
  assign bus.memwdata  = w_busy ? r_wdata  : 32'd0;
  assign bus.membyteen = w_busy ? r_byteen : 4'd0;
  assign bus.memrwb    = w_busy ? r_rwb    : 1'b1;

  assign bus.wbdone = w_done && (r_owner == OWN_WB);
  assign bus.ddone  = w_done && (r_owner == OWN_D);
  assign bus.idone  = w_done && (r_owner == OWN_I);
  assign bus.err    = w_done && r_err;
  assign bus.rdata  = r_rdata;

  assign bus.dbg_state = r_state;
  assign bus.dbg_owner = r_owner;
  assign bus.dbg_wbcnt = 8'(r_wbcnt);
endmodule

// File: tb/tb_membus_arbiter.sv
// Directed bench for membus_arbiter: a vector table of arbitration scenarios
// plus hand sequences for WB starvation, timeout, reset abort and stray memdone.
module tb_membus_arbiter;
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_WB   = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;
  localparam logic [1:0] OWN_I    = 2'd3;

  localparam logic [26:0] WB_ADR = 27'h0000111;
  localparam logic [26:0] D_ADR  = 27'h00000AD;
  localparam logic [26:0] I_ADR  = 27'h0000222;
  localparam logic [31:0] WB_WD  = 32'h11112222;
  localparam logic [31:0] D_WD   = 32'h33334444;
  localparam logic [31:0] I_WD   = 32'h55556666;
  localparam logic [3:0]  WB_BE  = 4'hF;
  localparam logic [3:0]  D_BE   = 4'h3;
  localparam logic [3:0]  I_BE   = 4'hC;

  logic ph1;
  logic resetb;
  int   checks;
  int   errors;

  membus_arbiter_if bus ();

  membus_arbiter #(.MAXWB(4), .TIMEOUT(255)) dut (
    .ph1    (ph1),
    .resetb (resetb),
    .bus    (bus)
  );

  // clock / reset
  initial ph1 = 1'b0;
  always #5 ph1 = ~ph1;

  typedef struct {
    string       name;
    logic        wb;
    logic        d;
    logic        i;
    logic        swc;
    logic        drwb;
    logic        irwb;
    int          lat;
    logic [31:0] rd;
    logic [1:0]  ord0;
    logic [1:0]  ord1;
    logic [1:0]  ord2;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic logic [26:0] adr_of(input logic [1:0] own);
    return (own == OWN_WB) ? WB_ADR : (own == OWN_D) ? D_ADR : I_ADR;
  endfunction

  function automatic logic [31:0] wd_of(input logic [1:0] own);
    return (own == OWN_WB) ? WB_WD : (own == OWN_D) ? D_WD : I_WD;
  endfunction

  function automatic logic [3:0] be_of(input logic [1:0] own);
    return (own == OWN_WB) ? WB_BE : (own == OWN_D) ? D_BE : I_BE;
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] own);
    return (own == OWN_WB) ? 3'b100 : (own == OWN_D) ? 3'b010 : 3'b001;
  endfunction

  function automatic logic [2:0] dones();
    return {bus.wbdone, bus.ddone, bus.idone};
  endfunction

  // Driver: serve one granted transaction, memdone in the lat-th BUSY cycle.
  task automatic do_txn(input string nm, input logic [1:0] own, input int lat,
                        input logic [31:0] rd, input bit drop);
    int   n;
    logic rd_op;
    n = 0;
    while (bus.memen !== 1'b1 && n < 40) begin
      @(negedge ph1);
      n++;
    end
    chk({nm, " grant"}, {31'd0, bus.memen}, 32'd1);
    if (bus.memen !== 1'b1) return;
    rd_op = (own == OWN_D) ? bus.drwb : (own == OWN_I) ? bus.irwb : 1'b0;
    for (int c = 1; c <= lat; c++) begin
      chk({nm, " memadr"}, {5'd0, bus.memadr}, {5'd0, adr_of(own)});
      chk({nm, " busy_done"}, {29'd0, dones()}, 32'd0);
      if (c == 1) begin
        chk({nm, " memwdata"}, bus.memwdata, wd_of(own));
        chk({nm, " membyteen"}, {28'd0, bus.membyteen}, {28'd0, be_of(own)});
        chk({nm, " memrwb"}, {31'd0, bus.memrwb}, {31'd0, rd_op});
      end
      if (c == lat) begin
        bus.memdone  = 1'b1;
        bus.memrdata = rd;
      end
      @(negedge ph1);
    end
    bus.memdone  = 1'b0;
    bus.memrdata = 32'd0;
    chk({nm, " done"}, {29'd0, dones()}, {29'd0, onehot(own)});
    chk({nm, " err"}, {31'd0, bus.err}, 32'd0);
    chk({nm, " memen_done"}, {31'd0, bus.memen}, 32'd0);
    if (rd_op) chk({nm, " rdata"}, bus.rdata, rd);
    if (drop) begin
      if (own == OWN_WB) bus.wbreq = 1'b0;
      if (own == OWN_D)  bus.dreq  = 1'b0;
      if (own == OWN_I)  bus.ireq  = 1'b0;
    end
    @(negedge ph1);
    chk({nm, " memen_idle"}, {31'd0, bus.memen}, 32'd0);
    chk({nm, " idle_done"}, {29'd0, dones()}, 32'd0);
  endtask

  initial begin
    int n;
    checks = 0;
    errors = 0;

    //            name        wb    d     i     swc   drwb  irwb  lat rd              ord0    ord1      ord2
    vecs[0] = '{"d_read",     1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3, 32'hBEADBEEF, OWN_D,  OWN_NONE, OWN_NONE};
    vecs[1] = '{"wb_only",    1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1, 32'h00000000, OWN_WB, OWN_NONE, OWN_NONE};
    vecs[2] = '{"all_swc0",   1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2, 32'hA5A50001, OWN_WB, OWN_D,    OWN_I};
    vecs[3] = '{"all_swc1",   1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1, 32'hA5A50002, OWN_WB, OWN_I,    OWN_D};
    vecs[4] = '{"di_dwrite",  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4, 32'hC0DE0004, OWN_D,  OWN_I,    OWN_NONE};
    vecs[5] = '{"i_read",     1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5, 32'h12345678, OWN_I,  OWN_NONE, OWN_NONE};

    resetb       = 1'b0;
    bus.swc      = 1'b0;
    bus.wbreq    = 1'b0;
    bus.wbadr    = WB_ADR;
    bus.wbwdata  = WB_WD;
    bus.wbbyteen = WB_BE;
    bus.dreq     = 1'b0;
    bus.drwb     = 1'b1;
    bus.dadr     = D_ADR;
    bus.dwdata   = D_WD;
    bus.dbyteen  = D_BE;
    bus.ireq     = 1'b0;
    bus.irwb     = 1'b1;
    bus.iadr     = I_ADR;
    bus.iwdata   = I_WD;
    bus.ibyteen  = I_BE;
    bus.memrdata = 32'd0;
    bus.memdone  = 1'b0;

    repeat (2) @(negedge ph1);
    chk("rst memen",  {31'd0, bus.memen}, 32'd0);
    chk("rst memrwb", {31'd0, bus.memrwb}, 32'd1);
    chk("rst done",   {29'd0, dones()}, 32'd0);
    chk("rst err",    {31'd0, bus.err}, 32'd0);
    chk("rst rdata",  bus.rdata, 32'd0);
    chk("rst state",  {30'd0, bus.dbg_state}, 32'd0);
    chk("rst owner",  {30'd0, bus.dbg_owner}, 32'd0);
    chk("rst wbcnt",  {24'd0, bus.dbg_wbcnt}, 32'd0);
    resetb = 1'b1;
    @(negedge ph1);

    // Table-driven arbitration scenarios.
    foreach (vecs[v]) begin
      bus.swc   = vecs[v].swc;
      bus.drwb  = vecs[v].drwb;
      bus.irwb  = vecs[v].irwb;
      bus.wbreq = vecs[v].wb;
      bus.dreq  = vecs[v].d;
      bus.ireq  = vecs[v].i;
      do_txn({vecs[v].name, ".0"}, vecs[v].ord0, vecs[v].lat, vecs[v].rd, 1'b1);
      if (vecs[v].ord1 != OWN_NONE)
        do_txn({vecs[v].name, ".1"}, vecs[v].ord1, vecs[v].lat, vecs[v].rd ^ 32'h00FF0000, 1'b1);
      if (vecs[v].ord2 != OWN_NONE)
        do_txn({vecs[v].name, ".2"}, vecs[v].ord2, vecs[v].lat, vecs[v].rd ^ 32'hFF000000, 1'b1);
      repeat (2) @(negedge ph1);
      chk({vecs[v].name, " quiet"}, {31'd0, bus.memen}, 32'd0);
    end

    // WB starvation limit: four WB grants, then the waiting dcache, then WB.
    bus.swc   = 1'b0;
    bus.drwb  = 1'b1;
    bus.wbreq = 1'b1;
    bus.dreq  = 1'b1;
    for (int k = 0; k < 4; k++) do_txn("starve_wb", OWN_WB, 1, 32'd0, 1'b0);
    chk("starve wbcnt_sat", {24'd0, bus.dbg_wbcnt}, 32'd4);
    do_txn("starve_d", OWN_D, 2, 32'h0D0D0D0D, 1'b1);
    chk("starve wbcnt_clr", {24'd0, bus.dbg_wbcnt}, 32'd0);
    do_txn("starve_wb_resume", OWN_WB, 1, 32'd0, 1'b1);
    chk("starve wbcnt_end", {24'd0, bus.dbg_wbcnt}, 32'd0);
    repeat (2) @(negedge ph1);

    // Timeout: memdone never arrives.
    bus.irwb = 1'b1;
    bus.ireq = 1'b1;
    n = 0;
    while (bus.memen !== 1'b1 && n < 40) begin
      @(negedge ph1);
      n++;
    end
    chk("to grant", {31'd0, bus.memen}, 32'd1);
    n = 0;
    while (bus.memen === 1'b1 && n < 400) begin
      chk("to busy_done", {29'd0, dones()}, 32'd0);
      @(negedge ph1);
      n++;
    end
    chk("to busy_cycles", n, 32'd255);
    chk("to idone", {29'd0, dones()}, 32'b001);
    chk("to err", {31'd0, bus.err}, 32'd1);
    chk("to rdata", bus.rdata, 32'hDEADBEEF);
    bus.ireq = 1'b0;
    @(negedge ph1);
    chk("to err_clear", {31'd0, bus.err}, 32'd0);
    chk("to done_clear", {29'd0, dones()}, 32'd0);

    // memdone while idle must be ignored.
    bus.memdone = 1'b1;
    repeat (2) @(negedge ph1);
    chk("stray memen", {31'd0, bus.memen}, 32'd0);
    chk("stray done",  {29'd0, dones()}, 32'd0);
    chk("stray state", {30'd0, bus.dbg_state}, 32'd0);
    bus.memdone = 1'b0;
    @(negedge ph1);

    // Reset during a WB transaction aborts silently; held wbreq re-granted.
    bus.wbreq = 1'b1;
    n = 0;
    while (bus.memen !== 1'b1 && n < 40) begin
      @(negedge ph1);
      n++;
    end
    chk("rstwb grant", {31'd0, bus.memen}, 32'd1);
    @(negedge ph1);
    resetb = 1'b0;
    #1;
    chk("rstwb memen",  {31'd0, bus.memen}, 32'd0);
    chk("rstwb memrwb", {31'd0, bus.memrwb}, 32'd1);
    chk("rstwb byteen", {28'd0, bus.membyteen}, 32'd0);
    chk("rstwb done",   {29'd0, dones()}, 32'd0);
    chk("rstwb rdata",  bus.rdata, 32'd0);
    @(negedge ph1);
    chk("rstwb hold_done", {29'd0, dones()}, 32'd0);
    resetb = 1'b1;
    @(negedge ph1);
    chk("rstwb first_grant", {31'd0, bus.memen}, 32'd1);
    chk("rstwb first_adr", {5'd0, bus.memadr}, {5'd0, WB_ADR});
    do_txn("rstwb_regrant", OWN_WB, 2, 32'd0, 1'b1);

    repeat (3) @(negedge ph1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/membus_arbiter.md
MEMBUS_ARBITER -- requirements
Module: membus_arbiter

Interface
REQ-001 SHALL have parameter MAXWB, default 4: max consecutive write-buffer grants while a cache request waits.
REQ-002 SHALL have parameter TIMEOUT, default 255: BUSY cycles without memdone before abort; 8-bit counter.
REQ-003 SHALL have port ph1 input 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port resetb input 1: asynchronous, active-low reset.
REQ-005 SHALL have port swc input 1: cache swap; 0 = dcache before icache, 1 = icache before dcache.
REQ-006 SHALL have ports wbreq, wbadr, wbwdata, wbbyteen as inputs of width 1/27/32/4: write-buffer write request.
REQ-007 SHALL have ports dreq, drwb, dadr, dwdata, dbyteen as inputs of width 1/1/27/32/4: dcache request; drwb 1 = read.
REQ-008 SHALL have ports ireq, irwb, iadr, iwdata, ibyteen as inputs of width 1/1/27/32/4: icache request; irwb 1 = read.
REQ-009 SHALL have ports wbdone, ddone, idone as outputs of width 1 each: one-cycle completion pulse per requester.
REQ-010 SHALL have port rdata output 32: read data captured from memrdata; valid during the ddone/idone pulse.
REQ-011 SHALL have port err output 1: one-cycle pulse, coincident with done, when the transaction timed out.
REQ-012 SHALL have ports memadr, memwdata, membyteen, memrwb, memen as outputs of width 27/32/4/1/1: main-memory bus.
REQ-013 SHALL have ports memrdata input 32 and memdone input 1: main-memory read data and completion.

Function
REQ-014 SHALL implement states IDLE, BUSY, DONE, plus an owner register (NONE/WB/D/I).
REQ-015 IDLE: with any request asserted, SHALL latch the winner's adr/wdata/byteen/rwb and owner, then enter BUSY next edge; otherwise stay in IDLE.
REQ-016 Priority SHALL be WB > first cache > second cache, where the cache order is set by swc sampled in IDLE.
REQ-017 When wbcnt == MAXWB and dreq|ireq, SHALL rank the caches above WB for that arbitration.
REQ-018 wbcnt SHALL increment on each WB grant made while dreq|ireq, saturating at MAXWB.
REQ-019 wbcnt SHALL clear on any cache grant, and on a WB grant made with no cache request pending.
REQ-020 WB transactions SHALL drive memrwb=0; cache transactions SHALL drive memrwb from the latched rwb.
REQ-021 In BUSY, memen SHALL be 1 and memadr/memwdata/membyteen/memrwb SHALL come from the latched registers, stable for the whole transaction.
REQ-022 In IDLE/DONE, memen=0, memrwb=1, membyteen=0, and memadr=memwdata=0.
REQ-023 BUSY with memdone=1 SHALL capture memrdata into rdata (reads only) and enter DONE.
REQ-024 The timeout counter SHALL clear on entry to BUSY and increment each BUSY cycle with memdone=0.
REQ-025 When the timeout counter reaches TIMEOUT, SHALL enter DONE with err set for that DONE cycle and rdata=32'hDEADBEEF.
REQ-026 DONE SHALL last exactly one cycle, pulse the owner's done, then return to IDLE with owner=NONE.
REQ-027 Minimum latency SHALL be: request seen at edge N, memen high after N, memdone at edge N+k, done pulse after N+k.
REQ-028 Bus turnaround SHALL be ≥2 cycles between transactions (DONE, then IDLE).
REQ-029 A requester SHALL hold its req and payload until its done pulse; a req dropped during BUSY is ignored and the transaction completes normally.
REQ-030 memdone outside BUSY SHALL be ignored, as SHALL swc changes outside IDLE.
REQ-031 A request asserted in the same cycle as another's done SHALL NOT be granted until the next IDLE cycle.

Reset
REQ-032 resetb=0 SHALL immediately force IDLE, owner=NONE, memen=0, memrwb=1, and all done/err=0.
REQ-033 resetb=0 SHALL force rdata=0, wbcnt=0 and the timeout counter to 0.
REQ-034 Reset mid-BUSY SHALL abort without a done pulse; requesters re-issue after reset.
REQ-035 The first grant SHALL be possible at the first rising ph1 edge after resetb deasserts.

Verification
REQ-036 Single dcache read: dreq=1, drwb=1, dadr=27'h0AD, memdone after 3 cycles, memrdata=32'hBEADBEEF -> memen for 3 cycles, ddone pulse, rdata=32'hBEADBEEF.
REQ-037 Simultaneous wbreq, dreq, ireq with swc=0 -> grant order WB, D, I; swc=1 -> WB, I, D; each done pulses exactly once.
REQ-038 Continuous wbreq with dreq held, MAXWB=4 -> 4 WB grants, then a D grant, then WB resumes; wbcnt returns to 0.
REQ-039 memdone never asserted, TIMEOUT=255 -> memen drops after 255 BUSY cycles, owner done and err pulse together, rdata=32'hDEADBEEF.
REQ-040 resetb low for 1 cycle during a WB transaction -> memen=0 immediately, no wbdone, and a held wbreq is re-granted after reset release.
